// File: rtl/mem_bus_arbiter.sv
// Single-port memory bus arbiter: data path has fixed priority over instruction fetch.
// Flushed fetches still complete on the bus but their data is dropped; hung transfers abort on timeout.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              inst_cancel_i,
  output logic              inst_ack_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  input  logic [3:0]        data_sel_i,
  output logic              data_ack_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [3:0]        bus_sel_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic              pause_if_o,
  output logic              pause_mem_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_D = 2'd1,
    BUSY_I = 2'd2
  } state_t;

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = (TIMEOUT > 0) ? TW'(TIMEOUT) : '0;

  state_t        state;
  logic          cancel;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_inc;
  logic          data_elig;
  logic          inst_elig;
  logic          cancel_now;
  logic          timed_out;

  // A requester acked this cycle is not eligible, so a held req is not granted twice.
  always_comb begin
    data_elig  = data_req_i & ~data_ack_o;
    inst_elig  = inst_req_i & ~inst_ack_o & ~inst_cancel_i;
    cancel_now = cancel | ((state == BUSY_I) & inst_cancel_i);
    timer_inc  = timer + TW'(1);
    if (TIMEOUT > 0) begin
      timed_out = (timer_inc == TLIM);
    end else begin
      timed_out = 1'b0;
    end
  end

  assign pause_if_o  = inst_req_i & ~inst_ack_o;
  assign pause_mem_o = data_req_i & ~data_ack_o;

  // Arbitration FSM with all bus-side and core-side outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cancel       <= 1'b0;
      timer        <= '0;
      inst_ack_o   <= 1'b0;
      inst_rdata_o <= '0;
      data_ack_o   <= 1'b0;
      data_rdata_o <= '0;
      bus_err_o    <= 1'b0;
      bus_req_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_wdata_o  <= '0;
      bus_sel_o    <= 4'h0;
    end else begin
      inst_ack_o <= 1'b0;
      data_ack_o <= 1'b0;
      bus_err_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (data_elig) begin
            state       <= BUSY_D;
            bus_req_o   <= 1'b1;
            bus_we_o    <= data_we_i;
            bus_addr_o  <= data_addr_i;
            bus_wdata_o <= data_wdata_i;
            bus_sel_o   <= data_sel_i;
            cancel      <= 1'b0;
            timer       <= '0;
          end else if (inst_elig) begin
            state       <= BUSY_I;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= inst_addr_i;
            bus_wdata_o <= '0;
            bus_sel_o   <= 4'hF;
            cancel      <= 1'b0;
            timer       <= '0;
          end else begin
            state <= IDLE;
          end
        end
        BUSY_D, BUSY_I: begin
          cancel <= cancel_now;
          // A bus ack in the same cycle as the timeout completes normally.
          if (bus_ack_i) begin
            state     <= IDLE;
            bus_req_o <= 1'b0;
            cancel    <= 1'b0;
            timer     <= '0;
            if (state == BUSY_D) begin
              data_ack_o   <= 1'b1;
              data_rdata_o <= bus_rdata_i;
            end else if (!cancel_now) begin
              inst_ack_o   <= 1'b1;
              inst_rdata_o <= bus_rdata_i;
            end
          end else if (timed_out) begin
            state     <= IDLE;
            bus_req_o <= 1'b0;
            cancel    <= 1'b0;
            timer     <= '0;
            if (state == BUSY_D) begin
              data_ack_o   <= 1'b1;
              bus_err_o    <= 1'b1;
              data_rdata_o <= '0;
            end else if (!cancel_now) begin
              inst_ack_o   <= 1'b1;
              bus_err_o    <= 1'b1;
              inst_rdata_o <= '0;
            end
          end else if (TIMEOUT > 0) begin
            timer <= timer_inc;
          end
        end
        default: begin
          state     <= IDLE;
          bus_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-level reference model, directed scenarios, random traffic
// with a reactive bus slave, and a per-cycle compare process.
module tb_mem_bus_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req_i, inst_cancel_i, inst_ack_o;
  logic [31:0] inst_addr_i, inst_rdata_o;
  logic        data_req_i, data_we_i, data_ack_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_sel_i;
  logic        bus_err_o, bus_req_o, bus_we_o, bus_ack_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_sel_o;
  logic        pause_if_o, pause_mem_o;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_cancel_i(inst_cancel_i),
    .inst_ack_o(inst_ack_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_sel_i(data_sel_i),
    .data_ack_o(data_ack_o), .data_rdata_o(data_rdata_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_sel_o(bus_sel_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .pause_if_o(pause_if_o), .pause_mem_o(pause_mem_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // reference model: one outstanding transaction record plus expected core-side outputs
  bit          m_busy = 1'b0, m_is_inst = 1'b0, m_cancel = 1'b0;
  int          m_age = 0;
  logic        e_inst_ack = 1'b0, e_data_ack = 1'b0, e_err = 1'b0;
  logic [31:0] e_inst_rdata = 32'h0, e_data_rdata = 32'h0;
  logic        e_bus_we = 1'b0;
  logic [31:0] e_bus_addr = 32'h0, e_bus_wdata = 32'h0;
  logic [3:0]  e_bus_sel = 4'h0;

  // bus slave
  bit          rand_mode = 1'b0;
  int          wait_cnt = 0, slave_lat = 0;
  logic [31:0] slave_data = 32'h0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_finish(input logic [31:0] d, input logic err);
    m_busy = 1'b0;
    if (!m_is_inst) begin
      e_data_ack = 1'b1; e_data_rdata = d; e_err = err;
    end else if (!m_cancel) begin
      e_inst_ack = 1'b1; e_inst_rdata = d; e_err = err;
    end
  endtask

  task automatic model_step();
    logic prev_ia, prev_da;
    prev_ia = e_inst_ack;
    prev_da = e_data_ack;
    e_inst_ack = 1'b0; e_data_ack = 1'b0; e_err = 1'b0;
    if (rst) begin
      m_busy = 1'b0; m_is_inst = 1'b0; m_cancel = 1'b0; m_age = 0;
      e_inst_rdata = 32'h0; e_data_rdata = 32'h0;
      e_bus_we = 1'b0; e_bus_addr = 32'h0; e_bus_wdata = 32'h0; e_bus_sel = 4'h0;
    end else if (!m_busy) begin
      if (data_req_i && !prev_da) begin
        m_busy = 1'b1; m_is_inst = 1'b0; m_cancel = 1'b0; m_age = 0;
        e_bus_we = data_we_i; e_bus_addr = data_addr_i;
        e_bus_wdata = data_wdata_i; e_bus_sel = data_sel_i;
      end else if (inst_req_i && !prev_ia && !inst_cancel_i) begin
        m_busy = 1'b1; m_is_inst = 1'b1; m_cancel = 1'b0; m_age = 0;
        e_bus_we = 1'b0; e_bus_addr = inst_addr_i; e_bus_sel = 4'hF;
      end
    end else begin
      if (m_is_inst && inst_cancel_i) m_cancel = 1'b1;
      if (bus_ack_i) model_finish(bus_rdata_i, 1'b0);
      else begin
        m_age++;
        if (TO > 0 && m_age == TO) model_finish(32'h0, 1'b1);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic slave_drive();
    if (rst || !bus_req_o) begin
      wait_cnt = 0;
      bus_ack_i = 1'b0;
    end else begin
      wait_cnt++;
      if (rand_mode && wait_cnt == 1) slave_lat = $urandom_range(0, 5);
      bus_ack_i = (wait_cnt > slave_lat);
      bus_rdata_i = rand_mode ? 32'($urandom) : slave_data;
    end
  endtask

  task automatic cyc();
    step();
    slave_drive();
  endtask

  task automatic new_data();
    data_addr_i  = 32'($urandom) & 32'hFFFF_FFFC;
    data_we_i    = 1'($urandom_range(0, 1));
    data_wdata_i = 32'($urandom);
    data_sel_i   = 4'($urandom_range(1, 15));
  endtask

  task automatic rand_drive();
    rst = ($urandom_range(0, 299) == 0);
    slave_drive();
    inst_cancel_i = ($urandom_range(0, 11) == 0);
    if (data_req_i) begin
      if (data_ack_o) begin
        if ($urandom_range(0, 1) == 0) data_req_i = 1'b0;
        else new_data();
      end
    end else if ($urandom_range(0, 3) == 0) begin
      data_req_i = 1'b1;
      new_data();
    end
    if (inst_req_i) begin
      if (inst_ack_o && $urandom_range(0, 2) == 0) inst_req_i = 1'b0;
      else if (inst_ack_o || inst_cancel_i) inst_addr_i = 32'($urandom) & 32'hFFFF_FFFC;
    end else if ($urandom_range(0, 1) == 0) begin
      inst_req_i  = 1'b1;
      inst_addr_i = 32'($urandom) & 32'hFFFF_FFFC;
    end
  endtask

  // per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk1("inst_ack", inst_ack_o, e_inst_ack);
      chk1("data_ack", data_ack_o, e_data_ack);
      chk1("bus_err", bus_err_o, e_err);
      chk32("inst_rdata", inst_rdata_o, e_inst_rdata);
      chk32("data_rdata", data_rdata_o, e_data_rdata);
      chk1("bus_req", bus_req_o, m_busy);
      if (m_busy) begin
        chk32("bus_addr", bus_addr_o, e_bus_addr);
        chk1("bus_we", bus_we_o, e_bus_we);
        chk32("bus_sel", {28'h0, bus_sel_o}, {28'h0, e_bus_sel});
        if (e_bus_we) chk32("bus_wdata", bus_wdata_o, e_bus_wdata);
      end
      chk1("pause_if", pause_if_o, inst_req_i & ~e_inst_ack);
      chk1("pause_mem", pause_mem_o, data_req_i & ~e_data_ack);
    end
  end

  initial begin
    rst = 1'b1;
    inst_req_i = 1'b0; inst_addr_i = 32'h0; inst_cancel_i = 1'b0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = 32'h0;
    data_wdata_i = 32'h0; data_sel_i = 4'h0;
    bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
    step();
    chk_en = 1'b1;
    step();
    chk1("rst bus_req", bus_req_o, 1'b0);
    chk1("rst inst_ack", inst_ack_o, 1'b0);
    chk1("rst data_ack", data_ack_o, 1'b0);
    chk1("rst bus_err", bus_err_o, 1'b0);
    chk32("rst inst_rdata", inst_rdata_o, 32'h0);
    chk32("rst bus_addr", bus_addr_o, 32'h0);
    rst = 1'b0;

    // single fetch, bus acks one cycle after bus_req
    inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0000;
    slave_lat = 1; slave_data = 32'h0280_0404;
    #1 chk1("t1 pause c0", pause_if_o, 1'b1);
    cyc();
    chk1("t1 bus_req c1", bus_req_o, 1'b1);
    chk32("t1 bus_addr", bus_addr_o, 32'h1C00_0000);
    chk32("t1 bus_sel", {28'h0, bus_sel_o}, 32'hF);
    #1 chk1("t1 pause c1", pause_if_o, 1'b1);
    cyc();
    chk1("t1 ack c2", inst_ack_o, 1'b0);
    #1 chk1("t1 pause c2", pause_if_o, 1'b1);
    cyc();
    chk1("t1 ack c3", inst_ack_o, 1'b1);
    chk32("t1 rdata", inst_rdata_o, 32'h0280_0404);
    chk32("t1 model rdata", e_inst_rdata, 32'h0280_0404);
    #1 chk1("t1 pause c3", pause_if_o, 1'b0);
    inst_req_i = 1'b0;
    cyc();

    // simultaneous store and fetch: store wins
    inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0004;
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h100;
    data_wdata_i = 32'hDEAD_BEEF; data_sel_i = 4'b0011;
    slave_lat = 0; slave_data = 32'hAAAA_5555;
    cyc();
    chk1("t2 bus_we", bus_we_o, 1'b1);
    chk32("t2 bus_addr", bus_addr_o, 32'h100);
    chk32("t2 bus_sel", {28'h0, bus_sel_o}, 32'h3);
    chk32("t2 bus_wdata", bus_wdata_o, 32'hDEAD_BEEF);
    cyc();
    chk1("t2 data_ack", data_ack_o, 1'b1);
    chk1("t2 bus idle", bus_req_o, 1'b0);
    data_req_i = 1'b0; data_we_i = 1'b0;
    cyc();
    chk1("t2 fetch bus_req", bus_req_o, 1'b1);
    chk32("t2 fetch addr", bus_addr_o, 32'h1C00_0004);
    chk1("t2 fetch we", bus_we_o, 1'b0);
    cyc();
    chk1("t2 inst_ack", inst_ack_o, 1'b1);
    inst_req_i = 1'b0;
    cyc();

    // cancelled fetch: bus completes, data discarded, next fetch normal
    inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0008;
    slave_lat = 2; slave_data = 32'h1234_5678;
    cyc();
    inst_cancel_i = 1'b1; inst_addr_i = 32'h1C00_0100;
    cyc();
    inst_cancel_i = 1'b0;
    cyc();
    cyc();
    chk1("t3 no ack", inst_ack_o, 1'b0);
    chk1("t3 bus idle", bus_req_o, 1'b0);
    chk32("t3 rdata kept", inst_rdata_o, 32'hAAAA_5555);
    slave_lat = 0; slave_data = 32'hCAFE_F00D;
    cyc();
    chk32("t3 refetch addr", bus_addr_o, 32'h1C00_0100);
    cyc();
    chk1("t3 refetch ack", inst_ack_o, 1'b1);
    chk32("t3 refetch rdata", inst_rdata_o, 32'hCAFE_F00D);
    inst_req_i = 1'b0;
    cyc();

    // load that times out after TO busy cycles
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h300; slave_lat = 100;
    for (int i = 1; i <= TO; i++) begin
      cyc();
      chk1("t4 bus_req held", bus_req_o, 1'b1);
      chk1("t4 no early ack", data_ack_o, 1'b0);
    end
    cyc();
    chk1("t4 data_ack", data_ack_o, 1'b1);
    chk1("t4 bus_err", bus_err_o, 1'b1);
    chk32("t4 rdata", data_rdata_o, 32'h0);
    chk1("t4 bus_req drop", bus_req_o, 1'b0);
    data_req_i = 1'b0;
    cyc();

    // bus ack in the timeout cycle completes normally
    data_req_i = 1'b1; data_addr_i = 32'h500; slave_lat = TO - 1; slave_data = 32'h0BAD_CAFE;
    for (int i = 1; i <= TO; i++) cyc();
    cyc();
    chk1("t4b data_ack", data_ack_o, 1'b1);
    chk1("t4b no err", bus_err_o, 1'b0);
    chk32("t4b rdata", data_rdata_o, 32'h0BAD_CAFE);
    data_req_i = 1'b0;
    cyc();

    // back-to-back loads with req held across the ack
    data_req_i = 1'b1; data_addr_i = 32'h200; slave_lat = 0; slave_data = 32'h1111_1111;
    cyc();
    chk32("t5 addr0", bus_addr_o, 32'h200);
    cyc();
    chk1("t5 ack0", data_ack_o, 1'b1);
    chk32("t5 rdata0", data_rdata_o, 32'h1111_1111);
    data_addr_i = 32'h204; slave_data = 32'h2222_2222;
    cyc();
    chk1("t5 no dup grant", bus_req_o, 1'b0);
    cyc();
    chk1("t5 req1", bus_req_o, 1'b1);
    chk32("t5 addr1", bus_addr_o, 32'h204);
    cyc();
    chk1("t5 ack1", data_ack_o, 1'b1);
    chk32("t5 rdata1", data_rdata_o, 32'h2222_2222);
    data_req_i = 1'b0;
    cyc();

    // cancelled fetch that times out: no ack, no error
    inst_req_i = 1'b1; inst_addr_i = 32'h1C00_0200; slave_lat = 100;
    cyc();
    inst_cancel_i = 1'b1;
    cyc();
    inst_cancel_i = 1'b0; inst_req_i = 1'b0;
    for (int i = 0; i < TO - 1; i++) cyc();
    chk1("t7 no ack", inst_ack_o, 1'b0);
    chk1("t7 no err", bus_err_o, 1'b0);
    chk1("t7 bus_req drop", bus_req_o, 1'b0);
    cyc();

    // reset while a load is outstanding
    data_req_i = 1'b1; data_addr_i = 32'h400; slave_lat = 100;
    cyc();
    chk1("t6 busy", bus_req_o, 1'b1);
    rst = 1'b1;
    cyc();
    chk1("t6 bus_req", bus_req_o, 1'b0);
    chk1("t6 data_ack", data_ack_o, 1'b0);
    rst = 1'b0; data_req_i = 1'b0;
    cyc();
    cyc();
    chk1("t6 stays idle", bus_req_o, 1'b0);

    // randomized traffic
    rand_mode = 1'b1;
    repeat (4000) begin
      step();
      rand_drive();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
